// File: rtl/multiplexer_4to1_pkg.sv
// Shared constants and types for the 4-to-1 lane multiplexer.
// Lane-select encoding and geometry are used by the interface, the RTL and the bench.
package multiplexer_4to1_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_LANE0 = 2'd0;
    localparam sel_t SEL_LANE1 = 2'd1;
    localparam sel_t SEL_LANE2 = 2'd2;
    localparam sel_t SEL_LANE3 = 2'd3;

endpackage

// File: rtl/multiplexer_4to1_if.sv
// Bus bundle for the 4-to-1 multiplexer.
// The master drives the lanes and the select; the slave returns the selected lane, both raw and registered.
interface multiplexer_4to1_if
    import multiplexer_4to1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
);

    logic [LANES*WIDTH-1:0] W;
    sel_t                   S;
    logic [WIDTH-1:0]       f;
    logic [WIDTH-1:0]       f_q;

    modport master (output W, output S, input f, input f_q);
    modport slave  (input W, input S, output f, output f_q);

endinterface

// File: rtl/multiplexer_4to1_mux2.sv
// WIDTH-bit 2-to-1 multiplexer used as the leaf of the 4-to-1 select tree.
// A non-binary select drives all zeros in simulation.
module multiplexer_4to1_mux2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            1'b0:    y = a;
            1'b1:    y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/multiplexer_4to1.sv
// Four-lane WIDTH-bit multiplexer with zero-latency output f and a registered copy f_q.
// f is a two-level mux2 tree; only f_q is affected by the synchronous reset.
module multiplexer_4to1
    import multiplexer_4to1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                clk,
    input  logic                reset,
    multiplexer_4to1_if.slave   bus
);

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] lane2;
    logic [WIDTH-1:0] lane3;
    logic [WIDTH-1:0] lower;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] sel_out;

    assign lane0 = bus.W[0*WIDTH +: WIDTH];
    assign lane1 = bus.W[1*WIDTH +: WIDTH];
    assign lane2 = bus.W[2*WIDTH +: WIDTH];
    assign lane3 = bus.W[3*WIDTH +: WIDTH];

    // S[0] picks within each pair, S[1] picks the pair
    multiplexer_4to1_mux2 #(.WIDTH(WIDTH)) u_mux_lower (
        .a   (lane0),
        .b   (lane1),
        .sel (bus.S[0]),
        .y   (lower)
    );

    multiplexer_4to1_mux2 #(.WIDTH(WIDTH)) u_mux_upper (
        .a   (lane2),
        .b   (lane3),
        .sel (bus.S[0]),
        .y   (upper)
    );

    multiplexer_4to1_mux2 #(.WIDTH(WIDTH)) u_mux_final (
        .a   (lower),
        .b   (upper),
        .sel (bus.S[1]),
        .y   (sel_out)
    );

    assign bus.f = sel_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.f_q <= '0;
        end else begin
            bus.f_q <= sel_out;
        end
    end

endmodule

// File: tb/tb_multiplexer_4to1.sv
// Directed self-checking bench for multiplexer_4to1 at WIDTH=1 and WIDTH=8.
// Expected values are hand-computed constants or taken directly from the lane definition.
module tb_multiplexer_4to1;
    import multiplexer_4to1_pkg::*;

    logic clk;
    logic reset;
    int   n_asserts;
    int   n_fails;

    multiplexer_4to1_if #(.WIDTH(1)) b1 ();
    multiplexer_4to1_if #(.WIDTH(8)) b8 ();

    multiplexer_4to1 #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    multiplexer_4to1 #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] sweep_ones;
        logic [3:0]  wv;
        logic [7:0]  exp8 [4];

        n_asserts  = 0;
        n_fails    = 0;
        sweep_ones = 16'b1100_1000_0100_0000;
        exp8[0] = 8'hAA; exp8[1] = 8'hBB; exp8[2] = 8'hCC; exp8[3] = 8'hDD;

        reset = 1'b1;
        b1.W  = '0;
        b1.S  = SEL_LANE0;
        b8.W  = '0;
        b8.S  = SEL_LANE0;

        // reset state of the registered output
        @(posedge clk); #1;
        check("reset_fq_w1", 8'(b1.f_q), 8'h00);
        check("reset_fq_w8", b8.f_q, 8'h00);

        // W=i, S=i[1:0] sweep; f high only for i = 6, 11, 14, 15
        for (int i = 0; i < 16; i++) begin
            b1.W = 4'(i);
            b1.S = 2'(i);
            #10;
            check($sformatf("diag_sweep_%0d", i), 8'(b1.f), 8'(sweep_ones[i]));
        end

        // every W against every S
        for (int w = 0; w < 16; w++) begin
            for (int s = 0; s < 4; s++) begin
                wv   = 4'(w);
                b1.W = wv;
                b1.S = 2'(s);
                #1;
                check($sformatf("full_w%0h_s%0d", w, s), 8'(b1.f), 8'(wv[s]));
            end
        end

        // WIDTH=8 lane extraction
        b8.W = 32'hDD_CC_BB_AA;
        for (int s = 0; s < 4; s++) begin
            b8.S = 2'(s);
            #1;
            check($sformatf("w8_lane%0d", s), b8.f, exp8[s]);
        end

        // register path out of reset
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reg_reset_fq", 8'(b1.f_q), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        b1.W  = 4'b1000;
        b1.S  = SEL_LANE3;
        #1;
        check("reg_f_immediate", 8'(b1.f), 8'h01);
        check("reg_fq_before_edge", 8'(b1.f_q), 8'h00);
        @(posedge clk); #1;
        check("reg_fq_after_edge", 8'(b1.f_q), 8'h01);
        check("w8_fq_lane3", b8.f_q, 8'hDD);

        // reset mid-stream clears f_q but not f
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_fq", 8'(b1.f_q), 8'h00);
        check("mid_reset_f", 8'(b1.f), 8'h01);
        check("mid_reset_w8_f", b8.f, 8'hDD);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("resume_fq", 8'(b1.f_q), 8'h01);

        // select changes with W fixed at 0101
        @(negedge clk);
        b1.W = 4'b0101;
        b1.S = SEL_LANE0; #1; check("s_walk_0", 8'(b1.f), 8'h01);
        b1.S = SEL_LANE1; #1; check("s_walk_1", 8'(b1.f), 8'h00);
        b1.S = SEL_LANE2; #1; check("s_walk_2", 8'(b1.f), 8'h01);
        b1.S = SEL_LANE3; #1; check("s_walk_3", 8'(b1.f), 8'h00);
        @(posedge clk); #1;
        check("s_walk_fq", 8'(b1.f_q), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
